// File: rtl/cpu8_bus_ctrl.sv
// Memory/IO subsystem behind the 8-bit CPU bus: 112 B RAM, 128 B programmable ROM and an
// I/O page with an output byte FIFO, an input byte latch, sticky overflow status and a tick counter.
module cpu8_bus_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_write,
    output logic [7:0] cpu_rdata,
    input  logic       prog_we,
    input  logic [6:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    localparam logic [7:0] A_OUT    = 8'h70;
    localparam logic [7:0] A_STATUS = 8'h71;
    localparam logic [7:0] A_IN     = 8'h72;
    localparam logic [7:0] A_TICK   = 8'h73;

    logic [7:0] ram_mem  [0:111];
    logic [7:0] rom_mem  [0:127];
    logic [7:0] fifo_mem [0:FIFO_DEPTH-1];

    logic [7:0]    prev_addr_q, prev_addr_d;
    logic [7:0]    in_byte_q, in_byte_d;
    logic          in_full_q, in_full_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tick_q, tick_d;

    logic       is_ram;
    logic       is_io;
    logic       access_edge;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       drop;
    logic [7:0] status;

    assign is_ram      = (cpu_address < A_OUT);
    assign is_io       = (cpu_address[7:4] == 4'h7);
    // Read side effects fire once per address change, never on a held address or a write.
    assign access_edge = (cpu_address != prev_addr_q) && !cpu_write;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_mem[rd_ptr_q];
    assign in_ready   = !in_full_q;

    assign pop      = out_valid && out_ready;
    assign push_req = cpu_write && (cpu_address == A_OUT);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    assign status = {4'b0000, in_full_q, ovf_q, fifo_full, fifo_empty};

    always_comb begin
        prev_addr_d = cpu_address;
        in_byte_d   = in_byte_q;
        in_full_d   = in_full_q;
        ovf_d       = ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        presc_d     = presc_q;
        tick_d      = tick_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (cpu_write && (cpu_address == A_STATUS)) begin
            ovf_d = 1'b0;
        end

        if (in_valid && in_ready) begin
            in_full_d = 1'b1;
            in_byte_d = in_data;
        end else if (access_edge && (cpu_address == A_IN) && in_full_q) begin
            in_full_d = 1'b0;
        end

        if (presc_q == PRESC_TOP) begin
            presc_d = '0;
            tick_d  = tick_q + 8'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_addr_q <= 8'h00;
            in_byte_q   <= 8'h00;
            in_full_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            presc_q     <= '0;
            tick_q      <= 8'h00;
        end else begin
            prev_addr_q <= prev_addr_d;
            in_byte_q   <= in_byte_d;
            in_full_q   <= in_full_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
        end
    end

    // Storage arrays are never reset; the ROM program port stays live during reset.
    always_ff @(posedge clk) begin
        if (cpu_write && is_ram) begin
            ram_mem[cpu_address[6:0]] <= cpu_wdata;
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= cpu_wdata;
        end
        if (prog_we) begin
            rom_mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        cpu_rdata = 8'h00;
        if (cpu_address[7]) begin
            cpu_rdata = rom_mem[cpu_address[6:0]];
        end else if (is_io) begin
            case (cpu_address)
                A_STATUS: cpu_rdata = status;
                A_IN:     cpu_rdata = in_byte_q;
                A_TICK:   cpu_rdata = tick_q;
                default:  cpu_rdata = 8'h00;
            endcase
        end else begin
            cpu_rdata = ram_mem[cpu_address[6:0]];
        end
    end

endmodule
